// File: rtl/gf2m_trinomial_reduce.sv
`default_nettype none
// ============================================================================
// Module      : gf2m_trinomial_reduce
// Description : Iterative reduction of an unreduced 2M-1-bit carry-less
//               product modulo the trinomial x^M + x^K + 1. Each FOLD cycle
//               XORs the high half back into the low part at offsets 0 and K;
//               with 0 < K <= (M-1)/2 at most two non-trivial folds occur.
//               Valid/ready handshakes on input and output; no overlap
//               between operations.
// Ports       : clk       - clock, rising edge
//               rst       - synchronous active-high reset
//               in_valid  - in_data carries a product
//               in_ready  - block is idle and can accept a product
//               in_data   - [2M-2:0] unreduced polynomial, bit i = coeff x^i
//               out_valid - out_data holds a reduced result
//               out_ready - downstream accepts the result
//               out_folds - [1:0] folds used (only with GF2M_REDUCE_FOLDCNT_EN)
//               out_data  - [M-1:0] reduced polynomial, degree < M
// Options     : GF2M_REDUCE_FOLDCNT_EN adds the out_folds output port.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2m_trinomial_reduce #(
  parameter int M = 409,
  parameter int K = 87
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*M-2:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GF2M_REDUCE_FOLDCNT_EN
  output logic [1:0]       out_folds,
`endif
  output logic [M-1:0]     out_data
);

  localparam int c_IN_W = 2*M - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_IN_W-1:0]   r_acc;
  logic [c_IN_W-1:0]   w_acc_nxt;
  logic [1:0]          r_fold_cnt;
  logic [1:0]          w_fold_cnt_nxt;
  logic [M-1:0]        r_out_data;
  logic [M-1:0]        w_out_data_nxt;
  logic                r_out_valid;
  logic                w_out_valid_nxt;
`ifdef GF2M_REDUCE_FOLDCNT_EN
  logic [1:0]          r_out_folds;
  logic [1:0]          w_out_folds_nxt;
`endif

  // Split of the accumulator: everything at x^M and above must be folded.
  logic [M-2:0]        w_hi;
  logic [M-1:0]        w_lo;
  logic [c_IN_W-1:0]   w_hi_ext;
  logic [c_IN_W-1:0]   w_fold;

  assign w_hi     = r_acc[c_IN_W-1:M];
  assign w_lo     = r_acc[M-1:0];
  assign w_hi_ext = {{M{1'b0}}, w_hi};

  // x^M == x^K + 1, so hi*x^M folds to hi + hi*x^K. The shifted term stays
  // below x^(2M-1) because K <= (M-1)/2, so no bits are lost by the shift.
  assign w_fold = {{(M-1){1'b0}}, w_lo} ^ w_hi_ext ^ (w_hi_ext << K);

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef GF2M_REDUCE_FOLDCNT_EN
  assign out_folds = r_out_folds;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_fold_cnt_nxt  = r_fold_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
`ifdef GF2M_REDUCE_FOLDCNT_EN
    w_out_folds_nxt = r_out_folds;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_acc_nxt      = in_data;
          w_fold_cnt_nxt = 2'd0;
          w_state_nxt    = S_FOLD;
        end
      end
      S_FOLD: begin
        if (w_hi != '0) begin
          w_acc_nxt      = w_fold;
          w_fold_cnt_nxt = r_fold_cnt + 2'd1;
        end else begin
          w_out_data_nxt  = w_lo;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
`ifdef GF2M_REDUCE_FOLDCNT_EN
          w_out_folds_nxt = r_fold_cnt;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_fold_cnt  <= 2'd0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef GF2M_REDUCE_FOLDCNT_EN
      r_out_folds <= 2'd0;
`endif
    end else begin
      r_acc       <= w_acc_nxt;
      r_fold_cnt  <= w_fold_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifdef GF2M_REDUCE_FOLDCNT_EN
      r_out_folds <= w_out_folds_nxt;
`endif
    end
  end

  // A third fold would mean K violates its bound.
  a_fold_cnt_max : assert property (@(posedge clk) disable iff (rst)
                                    (r_fold_cnt != 2'd3));

endmodule
`default_nettype wire

// File: tb/tb_gf2m_trinomial_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2m_trinomial_reduce
// Description : Self-checking bench for gf2m_trinomial_reduce: reset state,
//               zero/one/two-fold latency and values, backpressure, reset
//               during an operation and a randomized stream checked against
//               a bit-serial reference reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2m_trinomial_reduce;

  localparam int M      = 409;
  localparam int K      = 87;
  localparam int W      = 2*M - 1;
  localparam int N_RAND = 1000;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_data;
`ifdef GF2M_REDUCE_FOLDCNT_EN
  logic [1:0]     out_folds;
`endif

  int n_checks;
  int n_pass;

  gf2m_trinomial_reduce #(.M(M), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GF2M_REDUCE_FOLDCNT_EN
    .out_folds (out_folds),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- models
  function automatic logic [W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [W-1:0] r;
    logic [W-1:0] sa;
    r  = '0;
    sa = {{(M-1){1'b0}}, a};
    for (int i = 0; i < M; i++) begin
      if (b[i]) r = r ^ sa;
      sa = sa << 1;
    end
    return r;
  endfunction

  // Bit-serial reduction: eliminate the top set bit using x^i = x^(i-M+K) + x^(i-M).
  function automatic logic [M-1:0] ref_reduce(input logic [W-1:0] p);
    logic [W-1:0] t;
    t = p;
    for (int i = W-1; i >= M; i--) begin
      if (t[i]) begin
        t[i]       = 1'b0;
        t[i-M]     = ~t[i-M];
        t[i-M+K]   = ~t[i-M+K];
      end
    end
    return t[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_poly();
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < M; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // ---------------------------------------------------------- stimulus aid
  // Presents d, waits for acceptance, then measures the number of edges after
  // the accept edge until out_valid is present at an edge (-1 on timeout).
  task automatic run_one(input logic [W-1:0] d, output int lat,
                         output logic [M-1:0] data, output logic [1:0] folds);
    int waited;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat   = -1;
    data  = '0;
    folds = 2'd0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat  = k;
        data = out_data;
`ifdef GF2M_REDUCE_FOLDCNT_EN
        folds = out_folds;
`endif
        break;
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data);
    else n_pass++;
`ifdef GF2M_REDUCE_FOLDCNT_EN
    n_checks++;
    if (out_folds !== 2'd0) $display("FAIL reset_out_folds: got %0d expected 0", out_folds);
    else n_pass++;
`endif
  endtask

  task automatic test_fold(input string name, input int bit_in, input int exp_lat,
                           input logic [M-1:0] exp_data, input logic [1:0] exp_folds);
    logic [W-1:0] d;
    int           lat;
    logic [M-1:0] data;
    logic [1:0]   folds;
    d = '0;
    d[bit_in] = 1'b1;
    run_one(d, lat, data, folds);
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (data !== exp_data) $display("FAIL %s_data: got %h expected %h", name, data, exp_data);
    else n_pass++;
`ifdef GF2M_REDUCE_FOLDCNT_EN
    n_checks++;
    if (folds !== exp_folds) $display("FAIL %s_folds: got %0d expected %0d", name, folds, exp_folds);
    else n_pass++;
`else
    if (folds !== 2'd0 && exp_folds === 2'd3) $display("note: unreachable");
`endif
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d1, d2;
    logic [M-1:0] e1, e2;
    int           waited, lat;
    d1 = '0; d1[409] = 1'b1;
    d2 = '0; d2[816] = 1'b1;
    e1 = '0; e1[87] = 1'b1; e1[0] = 1'b1;
    e2 = '0; e2[407] = 1'b1; e2[172] = 1'b1; e2[85] = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = d1;
    @(negedge clk);
    @(posedge clk); #1;          // d1 accepted at this edge
    in_data = d2;                // in_valid stays high with new data
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %b expected 1", c, out_valid);
      else n_pass++;
      n_checks++;
      if (out_data !== e1) $display("FAIL bp_out_data[%0d]: got %h expected %h", c, out_data, e1);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, in_ready);
      else n_pass++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready_before_handshake: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk);              // output handshake
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_after_handshake: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_valid_after_handshake: got %b expected 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;          // d2 accepted at this edge
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    n_checks++;
    if (lat !== 4) $display("FAIL bp_second_latency: got %0d expected 4", lat);
    else n_pass++;
    n_checks++;
    if (out_data !== e2) $display("FAIL bp_second_data: got %h expected %h", out_data, e2);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    int           seen;
    d = '0; d[816] = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    @(posedge clk); #1;          // accept edge t
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) seen++;
    @(posedge clk); #1;          // after t+1
    rst = 1'b1;
    @(negedge clk);
    if (out_valid) seen++;
    @(posedge clk); #1;          // reset sampled at t+2
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL rstmid_out_data: got %h expected 0", out_data);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rstmid_no_output: got %0d pulses expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [M-1:0] exp_q[$];
    int           sent, recv, cycles, stray;
    logic         drv_abort;
    sent = 0; recv = 0; cycles = 0; stray = 0;
    drv_abort = 1'b0;
    fork
      begin : driver
        logic [W-1:0] p;
        int           waited;
        for (int n = 0; n < N_RAND && !drv_abort; n++) begin
          p = clmul(rand_poly(), rand_poly());
          @(posedge clk); #1;
          in_valid = 1'b1;
          in_data  = p;
          waited   = 0;
          @(negedge clk);
          while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
          end
          if (!in_ready) begin
            drv_abort = 1'b1;
          end else begin
            exp_q.push_back(ref_reduce(p));
            sent++;
          end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin : monitor
        logic [M-1:0] e;
        while (recv < N_RAND && cycles < 40000 && !drv_abort) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          cycles++;
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL rand_unexpected_output[%0d]: got %h expected none", recv, out_data);
            end else begin
              e = exp_q.pop_front();
              if (out_data !== e) $display("FAIL rand_data[%0d]: got %h expected %h", recv, out_data, e);
              else n_pass++;
            end
            recv++;
          end
        end
      end
    join
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    n_checks++;
    if (recv !== N_RAND || sent !== N_RAND)
      $display("FAIL rand_count: got sent=%0d recv=%0d expected %0d", sent, recv, N_RAND);
    else n_pass++;
    n_checks++;
    if (stray !== 0 || exp_q.size() !== 0)
      $display("FAIL rand_leftover: got stray=%0d pending=%0d expected 0", stray, exp_q.size());
    else n_pass++;
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    logic [M-1:0] e0, e1, e2;
    n_checks = 0;
    n_pass   = 0;
    e0 = '0; e0[0] = 1'b1;
    e1 = '0; e1[87] = 1'b1; e1[0] = 1'b1;
    e2 = '0; e2[407] = 1'b1; e2[172] = 1'b1; e2[85] = 1'b1;

    test_reset();
    test_fold("no_fold",  0,   2, e0, 2'd0);
    test_fold("one_fold", 409, 3, e1, 2'd1);
    test_fold("two_fold", 816, 4, e2, 2'd2);
    test_backpressure();
    test_reset_mid();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf2m_trinomial_reduce.md
Name: gf2m_trinomial_reduce

Overview:
- Downstream neighbour of the Karatsuba/overlap multiplier tree in the 409-bit binary-field multiplier.
- Takes the unreduced 2M-1-bit carry-less product and reduces it modulo the trinomial x^M + x^K + 1. Default field is GF(2^409), with x^409 + x^87 + 1.
- Iterative fold engine with valid/ready handshakes on both sides. Each FOLD cycle does one XOR fold.

Parameters:
- M, 409, field degree; output width. Input width is 2M-1.
- K, 87, middle-term exponent. Requires 0 < K <= (M-1)/2, which guarantees at most 2 non-trivial folds.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a product.
- in_data  input  2M-1  unreduced polynomial; bit i is the coefficient of x^i.
- out_valid  output  1  out_data holds a reduced result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  M  reduced polynomial, degree < M.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, acc=0, out_data=0, out_valid=0, fold_cnt=0. rst has priority over every other event, including an in-flight operation; any partial result is discarded and no output is produced.
- acc is a 2M-1-bit register. hi = acc[2M-2:M] (M-1 bits). lo = acc[M-1:0].
- fold(acc) is a 2M-1-bit value: ({M-1'b0, lo}) ^ zero-extend(hi) ^ zero-extend(hi << K).
- in_ready = (state==IDLE). It is combinational from state only.
- States:
  - IDLE: when in_valid && in_ready, acc <= in_data, fold_cnt <= 0, go to FOLD. Otherwise hold.
  - FOLD: if hi != 0, then acc <= fold(acc), fold_cnt <= fold_cnt+1, stay in FOLD. If hi == 0, then out_data <= lo, out_valid <= 1, go to DONE.
  - DONE: out_valid=1. out_data is held stable. When out_ready, clear out_valid and go to IDLE. in_ready rises the cycle after the handshake.
- in_valid is ignored outside IDLE; in_data is not sampled.
- Latency is measured from the accept edge t:
  - product with hi==0: out_valid at t+2.
  - 1 fold needed: out_valid at t+3.
  - 2 folds needed: out_valid at t+4, which is the maximum.
- No input/output overlap. Max throughput is one result per (latency+1) cycles with out_ready held high.
- fold_cnt is 2 bits. It never exceeds 2 under the parameter constraint. An assertion (simulation only) flags fold_cnt==3.
- All arithmetic is GF(2): XOR only, no carries. Shifted bits beyond 2M-2 cannot occur under the constraint; truncation is not required and must not be relied on.
- out_valid is held high in DONE regardless of out_ready; it drops only on the handshake or on reset.

Optional Feature:
- Macro: GF2M_REDUCE_FOLDCNT_EN.
- When defined:
  - Adds output port out_folds (2 bits), registered and equal to fold_cnt at DONE entry.
  - out_folds is valid while out_valid=1, resets to 0 and holds otherwise.
- When undefined: the port is absent; fold_cnt remains internal and may be optimised away except for the assertion.

Test Plan:
- in_data=1, out_ready=1 -> out_data=1 (bit 0 only), out_valid at accept+2, out_folds=0.
- in_data=x^409 (bit 409 only) -> out_data bits {87,0} set, all others 0, out_valid at accept+3, out_folds=1.
- in_data=x^816 (bit 816 only) -> out_data bits {407,172,85} set, out_valid at accept+4, out_folds=2.
- Backpressure: x^409 input with out_ready=0 for 10 cycles and in_valid held high with new data -> out_valid=1 and out_data constant throughout, in_ready=0, second input accepted only on the cycle after out_ready=1.
- Reset mid-operation: accept x^816, assert rst for 1 cycle at accept+2 -> following cycle out_valid=0, in_ready=1, out_data=0, no output pulse ever seen for that input.
- Random: 1000 products from random 409-bit operand pairs, driven back-to-back with random out_ready stalls -> every out_data matches the software GF(2^409) reduction, in order, with no drops or duplicates.
